vga_sync_monitor: RTL and testbench

//   Receive-side counterpart of the VGA test-pattern/timing generators: consumes Hsync/Vsync/RGB at pixel clock,

---
 rtl/vga_sync_monitor_pkg.sv | 30 +++
 rtl/vga_sync_monitor_crc16.sv | 28 ++
 rtl/vga_sync_monitor.sv | 119 +++++++++++
 tb/tb_vga_sync_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_monitor_pkg.sv
// Shared types and constants for the VGA sync monitor: 640x480@60 default timing,
// lock FSM state encoding and the 3-bit-per-clock CRC-16-CCITT step.
package vga_sync_monitor_pkg;

  localparam int DEF_H_DISPLAY    = 640;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_H_SYNC_START = 656;
  localparam int DEF_V_DISPLAY    = 480;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_V_SYNC_START = 490;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Pixel bits enter MSB first: b, then g, then r.
  function automatic logic [15:0] crc16_step3(input logic [15:0] c, input logic [2:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 2; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? CRC_POLY : 16'h0000);
    return r;
  endfunction

endpackage

// File: rtl/vga_sync_monitor_crc16.sv
// vga_crc16: running CRC over enabled pixels; clear snapshots the running value
// into frame_crc and restarts from the init value.
module vga_crc16
  import vga_sync_monitor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [2:0]  data,
  output logic [15:0] frame_crc
);

  logic [15:0] crc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc       <= CRC_INIT;
      frame_crc <= '0;
    end else if (clear) begin
      frame_crc <= crc;
      crc       <= CRC_INIT;
    end else if (enable) begin
      crc <= crc16_step3(crc, data);
    end
  end

endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: flywheel hpos/vpos recovery, sync-edge checking and lock FSM.
// Frame CRC is built only when VGA_SYNC_MONITOR_CRC_EN is defined; otherwise frame_crc is 0.
module vga_sync_monitor
  import vga_sync_monitor_pkg::*;
#(
  parameter int H_DISPLAY       = DEF_H_DISPLAY,
  parameter int H_TOTAL         = DEF_H_TOTAL,
  parameter int H_SYNC_START    = DEF_H_SYNC_START,
  parameter int V_DISPLAY       = DEF_V_DISPLAY,
  parameter int V_TOTAL         = DEF_V_TOTAL,
  parameter int V_SYNC_START    = DEF_V_SYNC_START,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  rgb_in,
  output logic [2:0]  rgb_out,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic        locked,
  output logic        sync_error,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  mon_state_t state;
  logic [3:0] good, good_inc;
  logic       hs_q, vs_q;
  logic       h_edge, v_edge, h_wrap, h_mis, v_mis, mis, disp_next;
  logic [9:0] h_pred, v_pred, h_next, v_next;

  // hs_q/vs_q hold the previous raw sample; edges compare it against the live input
  // so every output lags the stream by exactly one clock.
  always_comb begin
    h_edge    = (hsync_in ^ SYNC_ACTIVE_LOW) & ~(hs_q ^ SYNC_ACTIVE_LOW);
    v_edge    = (vsync_in ^ SYNC_ACTIVE_LOW) & ~(vs_q ^ SYNC_ACTIVE_LOW);
    h_wrap    = (hpos == 10'(H_TOTAL - 1));
    h_pred    = h_wrap ? 10'd0 : hpos + 10'd1;
    v_pred    = vpos;
    if (h_wrap) v_pred = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    h_mis     = h_edge ^ (h_pred == 10'(H_SYNC_START));
    v_mis     = (h_pred == 10'd0) ? (v_edge ^ (v_pred == 10'(V_SYNC_START))) : v_edge;
    mis       = h_mis | v_mis;
    h_next    = h_edge ? 10'(H_SYNC_START) : h_pred;
    v_next    = v_edge ? 10'(V_SYNC_START) : v_pred;
    disp_next = (h_next < 10'(H_DISPLAY)) && (v_next < 10'(V_DISPLAY));
    good_inc  = good + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      good        <= '0;
      hs_q        <= SYNC_ACTIVE_LOW;
      vs_q        <= SYNC_ACTIVE_LOW;
      rgb_out     <= '0;
      hpos        <= '0;
      vpos        <= '0;
      display_on  <= 1'b0;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      hs_q       <= hsync_in;
      vs_q       <= vsync_in;
      rgb_out    <= rgb_in;
      hpos       <= h_next;
      vpos       <= v_next;
      display_on <= disp_next;
      sync_error <= mis && (state != SEARCH);
      case (state)
        SEARCH: if (v_edge) begin
          state <= VERIFY;
          good  <= '0;
        end
        VERIFY: if (mis) begin
          state <= SEARCH;
        end else if (v_edge) begin
          good <= good_inc;
          if (good_inc == 4'(LOCK_FRAMES)) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: if (mis) begin
          state  <= SEARCH;
          locked <= 1'b0;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else if (v_edge) begin
          frame_count <= frame_count + 16'd1;
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_SYNC_MONITOR_CRC_EN
  vga_crc16 u_crc (
    .clk       (clk),
    .reset     (reset),
    .clear     (v_edge),
    .enable    (disp_next),
    .data      (rgb_in),
    .frame_crc (frame_crc)
  );
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down raster so many frames fit in a short run.
module tb_vga_sync_monitor;
  localparam int HD = 5, HT = 9, HS = 6, HSW = 2;
  localparam int VD = 3, VT = 5, VS = 3, VSW = 1;
  localparam int LF = 2;

  logic        clk = 1'b0, reset = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [2:0]  rgb_in = 3'd0;
  logic [2:0]  rgb_out;
  logic [9:0]  hpos, vpos;
  logic        display_on, locked, sync_error;
  logic [15:0] frame_count, frame_crc;
  logic [7:0]  err_count;

  vga_sync_monitor #(
    .H_DISPLAY(HD), .H_TOTAL(HT), .H_SYNC_START(HS),
    .V_DISPLAY(VD), .V_TOTAL(VT), .V_SYNC_START(VS),
    .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .rgb_out(rgb_out), .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
    .sync_error(sync_error), .frame_count(frame_count), .err_count(err_count), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  typedef struct { int h; int v; logic d; logic [2:0] rgb; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  bit trk = 0;
  int err_pulses = 0, err_h = -1, err_v = -1;
  bit lock_seen = 0;
  int lock_h = -1, lock_v = -1;
  logic prev_locked = 1'b0, gen_vs_prev = 1'b0;
  logic [15:0] m_crc = 16'hFFFF, m_frame = 16'h0000;

  // Reference CRC: 17-bit shift, reduce by x^16+x^12+x^5+1.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [2:0] px);
    logic [16:0] t;
    t = {1'b0, c};
    for (int i = 2; i >= 0; i--) begin
      t = {t[15:0], px[i]};
      if (t[16]) t = t ^ 17'h11021;
    end
    return t[15:0];
  endfunction

  function automatic logic [15:0] ref_crc_frame(input logic [15:0] c, input logic [2:0] px);
    logic [15:0] r;
    r = c;
    // Reference augments with zeros differently; fold message bits in at the top instead.
    r = ref_crc(r ^ {px, 13'd0}, 3'd0);
    return r;
  endfunction

  task automatic pix(input int h, input int v, input bit drop_v, input bit glitch_h, input int pat);
    logic hs, vs, disp;
    logic [2:0] px;
    exp_t e;
    disp = (h < HD) && (v < VD);
    hs   = ((h >= HS) && (h < HS + HSW)) || glitch_h;
    vs   = (v >= VS) && (v < VS + VSW) && !drop_v;
    px   = !disp ? 3'd0 : (pat == 1) ? 3'd0 : (pat == 2) ? 3'd7 : 3'((h + v) & 7);
    hsync_in = ~hs;
    vsync_in = ~vs;
    rgb_in   = px;
    if (vs && !gen_vs_prev) begin
      m_frame = m_crc;
      m_crc   = 16'hFFFF;
    end else if (disp) begin
      m_crc = ref_crc_frame(m_crc, px);
    end
    gen_vs_prev = vs;
    if (trk) sb.push_back('{h, v, disp, px});
    @(posedge clk); #1;
    if (trk) begin
      e = sb.pop_front();
      checks++;
      if ({hpos, vpos, display_on, rgb_out, sync_error} !== {10'(e.h), 10'(e.v), e.d, e.rgb, 1'b0}) begin
        failures++;
        $display("FAIL track: hpos=%0d vpos=%0d disp=%0b rgb=%0d serr=%0b, expected %0d %0d %0b %0d 0",
                 hpos, vpos, display_on, rgb_out, sync_error, e.h, e.v, e.d, e.rgb);
      end
    end
    if (sync_error) begin
      err_pulses++;
      err_h = int'(hpos);
      err_v = int'(vpos);
    end
    if (locked && !prev_locked) begin
      lock_seen = 1;
      lock_h = h;
      lock_v = v;
    end
    prev_locked = locked;
  endtask

  task automatic frame(input int stretch_line, input bit drop_v, input bit glitch, input int pat);
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        pix(h, v, drop_v, glitch && (h == 0) && (v == VS), pat);
        if ((h == HT - 1) && (v == stretch_line)) pix(h, v, drop_v, 1'b0, pat);
      end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    gen_vs_prev = 1'b0; prev_locked = 1'b0; m_crc = 16'hFFFF; m_frame = 16'h0000;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rgb_out, hpos, vpos, display_on, locked, sync_error, frame_count, err_count, frame_crc} !== '0) begin
      failures++;
      $display("FAIL reset_state: hpos=%0d vpos=%0d rgb=%0d disp=%0b lock=%0b serr=%0b fc=%0d ec=%0d crc=%h, expected all 0",
               hpos, vpos, rgb_out, display_on, locked, sync_error, frame_count, err_count, frame_crc);
    end
    apply_reset();
  endtask

  task automatic test_lock();
    lock_seen = 0;
    for (int f = 0; f < 3; f++) begin
      frame(-1, 0, 0, 0);
      if (f < 2) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL early_lock: frame %0d locked=%0b expected 0", f, locked); end
      end
    end
    checks++;
    if (!(lock_seen && lock_h == 0 && lock_v == VS)) begin
      failures++;
      $display("FAIL lock_point: seen=%0b at h=%0d v=%0d, expected h=0 v=%0d", lock_seen, lock_h, lock_v, VS);
    end
    trk = 1; frame(-1, 0, 0, 0); trk = 0;
    checks++;
    if ({locked, frame_count, err_count} !== {1'b1, 16'd1, 8'd0}) begin
      failures++;
      $display("FAIL locked_counts: locked=%0b fc=%0d ec=%0d, expected 1 1 0", locked, frame_count, err_count);
    end
  endtask

  task automatic test_stretch();
    err_pulses = 0;
    frame(1, 0, 0, 0);
    checks++;
    if (!(err_pulses == 1 && err_h == HS && err_v == 2)) begin
      failures++;
      $display("FAIL stretch_err: pulses=%0d at h=%0d v=%0d, expected 1 at h=%0d v=2", err_pulses, err_h, err_v, HS);
    end
    checks++;
    if ({locked, err_count, frame_count} !== {1'b0, 8'd1, 16'd1}) begin
      failures++;
      $display("FAIL stretch_state: locked=%0b ec=%0d fc=%0d, expected 0 1 1", locked, err_count, frame_count);
    end
    frame(-1, 0, 0, 0);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL stretch_relock_early: locked=%0b expected 0", locked); end
    frame(-1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL stretch_relock: locked=%0b expected 1", locked); end
    trk = 1; frame(-1, 0, 0, 0); trk = 0;
    checks++;
    if (frame_count !== 16'd2) begin failures++; $display("FAIL frame_count: got %0d expected 2", frame_count); end
  endtask

  task automatic test_vdrop_saturate();
    err_pulses = 0;
    frame(-1, 1, 0, 0);
    checks++;
    if (!(err_pulses == 1 && err_h == 0 && err_v == VS)) begin
      failures++;
      $display("FAIL vdrop_err: pulses=%0d at h=%0d v=%0d, expected 1 at h=0 v=%0d", err_pulses, err_h, err_v, VS);
    end
    checks++;
    if ({locked, err_count} !== {1'b0, 8'd2}) begin
      failures++;
      $display("FAIL vdrop_state: locked=%0b ec=%0d, expected 0 2", locked, err_count);
    end
    repeat (3) frame(-1, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      frame(0, 0, 0, 0);
      frame(-1, 0, 0, 0);
      frame(-1, 0, 0, 0);
      if (i == 9) begin
        checks++;
        if (err_count !== 8'd12) begin failures++; $display("FAIL err_count_mid: got %0d expected 12", err_count); end
      end
    end
    checks++;
    if ({locked, err_count} !== {1'b1, 8'd255}) begin
      failures++;
      $display("FAIL err_saturate: locked=%0b ec=%0d, expected 1 255", locked, err_count);
    end
  endtask

  task automatic test_reset_midframe();
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < HT; h++) pix(h, v, 0, 0, 0);
    for (int h = 0; h < 3; h++) pix(h, 2, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({rgb_out, hpos, vpos, display_on, locked, sync_error, frame_count, err_count, frame_crc} !== '0) begin
      failures++;
      $display("FAIL midframe_reset: hpos=%0d vpos=%0d lock=%0b fc=%0d ec=%0d crc=%h, expected all 0",
               hpos, vpos, locked, frame_count, err_count, frame_crc);
    end
    apply_reset();
    lock_seen = 0;
    for (int f = 0; f < LF + 1; f++) begin
      frame(-1, 0, 0, 0);
      checks++;
      if (locked !== (f == LF)) begin
        failures++;
        $display("FAIL relock_after_reset: frame %0d locked=%0b expected %0b", f, locked, f == LF);
      end
    end
  endtask

  task automatic test_verify_hmis();
    apply_reset();
    frame(-1, 0, 0, 0);
    err_pulses = 0;
    frame(-1, 0, 1, 0);
    checks++;
    if ({err_pulses == 1, locked, err_count} !== {1'b1, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL verify_hmis: pulses=%0d locked=%0b ec=%0d, expected 1 0 0", err_pulses, locked, err_count);
    end
    for (int f = 0; f < 3; f++) begin
      frame(-1, 0, 0, 0);
      checks++;
      if (locked !== (f == 2)) begin
        failures++;
        $display("FAIL verify_restart: frame %0d locked=%0b expected %0b", f, locked, f == 2);
      end
    end
  endtask

  task automatic test_crc();
    logic [15:0] want;
    apply_reset();
    frame(-1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      frame(-1, 0, 0, (k == 0) ? 1 : (k == 1) ? 2 : 0);
`ifdef VGA_SYNC_MONITOR_CRC_EN
      want = m_frame;
`else
      want = 16'h0000;
`endif
      checks++;
      if (frame_crc !== want) begin
        failures++;
        $display("FAIL frame_crc: pattern %0d got %h expected %h", k, frame_crc, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stretch();
    test_vdrop_saturate();
    test_reset_midframe();
    test_verify_hmis();
    test_crc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
